// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; build with ALU_ARB_FIXED_PRI_EN for fixed priority to requester 0.
// Latency: result returned 2 edges after accept (issue stage, then response stage); one accept per cycle.
// Backpressure: req*_ready is the combinational grant; responses are single-cycle pulses with no backpressure.
module alu_arbiter #(
    parameter int DATA_W  = 16,
    parameter int OP_W    = 5,
    parameter int FUNCT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [OP_W-1:0]    req0_op,
    input  logic [FUNCT_W-1:0] req0_funct,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [OP_W-1:0]    req1_op,
    input  logic [FUNCT_W-1:0] req1_funct,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    output logic               req1_ready,
    input  logic               flush0,
    output logic [OP_W-1:0]    alu_op,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               resp0_valid,
    output logic               resp1_valid,
    output logic [DATA_W-1:0]  resp_data,
    output logic               busy
);

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [FUNCT_W-1:0] funct;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
    } op_t;

    op_t               w_req0_dat;
    op_t               w_req1_dat;
    op_t               w_sel_dat;
    op_t               r_iss_dat;
    logic              r_iss_vld;
    logic              r_iss_own;
    logic              w_elig0;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              r_resp0_vld;
    logic              r_resp1_vld;
    logic [DATA_W-1:0] r_resp_dat;

    assign w_req0_dat = {req0_op, req0_funct, req0_a, req0_b};
    assign w_req1_dat = {req1_op, req1_funct, req1_a, req1_b};

    // A flushing requester 0 is invisible to arbitration, so requester 1 wins as sole requester.
    assign w_elig0 = req0_valid & ~flush0;

`ifdef ALU_ARB_FIXED_PRI_EN
    assign w_grant0 = rst_n & w_elig0;
    assign w_grant1 = rst_n & req1_valid & ~w_elig0;
`else
    logic r_ptr;

    assign w_grant0 = rst_n & w_elig0 & (~req1_valid | ~r_ptr);
    assign w_grant1 = rst_n & req1_valid & (~w_elig0 | r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= w_grant0;
        end
    end
`endif

    assign w_accept   = w_grant0 | w_grant1;
    assign w_sel_dat  = w_grant1 ? w_req1_dat : w_req0_dat;
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_vld <= 1'b0;
            r_iss_own <= 1'b0;
            r_iss_dat <= '0;
        end else begin
            r_iss_vld <= w_accept;
            if (w_accept) begin
                r_iss_own <= w_grant1;
                r_iss_dat <= w_sel_dat;
            end
        end
    end

    // flush0 kills the owner-0 op sitting in issue; a response already visible is left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp0_vld <= 1'b0;
            r_resp1_vld <= 1'b0;
            r_resp_dat  <= '0;
        end else begin
            r_resp0_vld <= r_iss_vld & ~r_iss_own & ~flush0;
            r_resp1_vld <= r_iss_vld & r_iss_own;
            if (r_iss_vld) begin
                r_resp_dat <= alu_result;
            end
        end
    end

    assign alu_op      = r_iss_dat.op;
    assign alu_funct   = r_iss_dat.funct;
    assign alu_a       = r_iss_dat.a;
    assign alu_b       = r_iss_dat.b;
    assign resp0_valid = r_resp0_vld;
    assign resp1_valid = r_resp1_vld;
    assign resp_data   = r_resp_dat;
    assign busy        = r_iss_vld | r_resp0_vld | r_resp1_vld;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with an arbitration/latency reference model.
module tb_alu_arbiter;

    localparam logic [4:0] OP_ADD = 5'b11011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, flush0;
    logic [4:0]  req0_op, req1_op;
    logic [1:0]  req0_funct, req1_funct;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [4:0]  alu_op;
    logic [1:0]  alu_funct;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        resp0_valid, resp1_valid, busy;
    logic [15:0] resp_data;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_funct(req0_funct),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_funct(req1_funct),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .flush0(flush0),
        .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_data(resp_data), .busy(busy)
    );

    function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [1:0] f,
                                              input logic [15:0] a, input logic [15:0] b);
        if (op == OP_ADD) begin
            case (f)
                2'd0:    return a + b;
                2'd1:    return a - b;
                2'd2:    return a & b;
                default: return a | b;
            endcase
        end
        return a ^ {b[7:0], b[15:8]} ^ {11'd0, op};
    endfunction

    always_comb alu_result = alu_model(alu_op, alu_funct, alu_a, alu_b);

    typedef struct {
        int          owner;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          pref    = 0;
    bit          m_iss_vld = 0;
    logic [4:0]  m_op;
    logic [1:0]  m_f;
    logic [15:0] m_a, m_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set0(input bit v, input logic [4:0] op, input logic [1:0] f,
                        input logic [15:0] a, input logic [15:0] b);
        req0_valid = v; req0_op = op; req0_funct = f; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input bit v, input logic [4:0] op, input logic [1:0] f,
                        input logic [15:0] a, input logic [15:0] b);
        req1_valid = v; req1_op = op; req1_funct = f; req1_a = a; req1_b = b;
    endtask

    // Called 1 time unit after a rising edge with inputs already driven; returns at the same phase next cycle.
    task automatic tick();
        bit e0, e1, g0, g1, exp_busy;
        #1;
        if (flush0) begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].owner == 0 && q[i].due == cyc + 1) q.delete(i);
        end
        e0 = req0_valid && !flush0;
        e1 = req1_valid;
`ifdef ALU_ARB_FIXED_PRI_EN
        g0 = e0;
        g1 = e1 && !e0;
`else
        if (e0 && e1) begin
            g0 = (pref == 0);
            g1 = (pref == 1);
        end else begin
            g0 = e0;
            g1 = e1;
        end
        if (g0) pref = 1;
        if (g1) pref = 0;
`endif
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        exp_busy = m_iss_vld || (q.size() > 0 && q[0].due == cyc);
        chk("busy", busy, exp_busy);
        if (m_iss_vld) begin
            chk("alu_op", alu_op, m_op);
            chk("alu_funct", alu_funct, m_f);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
        end
        m_iss_vld = g0 || g1;
        if (g0) begin
            m_op = req0_op; m_f = req0_funct; m_a = req0_a; m_b = req0_b;
            q.push_back('{0, alu_model(req0_op, req0_funct, req0_a, req0_b), cyc + 2});
        end else if (g1) begin
            m_op = req1_op; m_f = req1_funct; m_a = req1_a; m_b = req1_b;
            q.push_back('{1, alu_model(req1_op, req1_funct, req1_a, req1_b), cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set0(0, 5'd0, 2'd0, 16'd0, 16'd0);
        set1(0, 5'd0, 2'd0, 16'd0, 16'd0);
        flush0 = 1'b0;
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        bit exp_v;
        exp_v = (q.size() > 0 && q[0].due == cyc);
        if (exp_v) begin
            chk("resp0_valid", resp0_valid, q[0].owner == 0);
            chk("resp1_valid", resp1_valid, q[0].owner == 1);
            chk("resp_data", resp_data, q[0].data);
            void'(q.pop_front());
        end else begin
            chk("resp0_idle", resp0_valid, 1'b0);
            chk("resp1_idle", resp1_valid, 1'b0);
        end
    end

    initial begin
        rst_n  = 1'b0;
        flush0 = 1'b0;
        set0(1, OP_ADD, 2'd0, 16'h1234, 16'h0001);
        set1(1, OP_ADD, 2'd0, 16'h4321, 16'h0002);
        #3;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_data", resp_data, 16'h0);
        chk("rst_alu", {alu_op, alu_funct, alu_a, alu_b}, 32'h0);
        chk("rst_alu_b", alu_b, 16'h0);
        set0(0, 5'd0, 2'd0, 16'd0, 16'd0);
        set1(0, 5'd0, 2'd0, 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // contention from reset pointer
        repeat (4) begin
            set0(1, OP_ADD, 2'($urandom), 16'($urandom), 16'($urandom));
            set1(1, OP_ADD, 2'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        idle(3);

        set0(1, OP_ADD, 2'd0, 16'h0003, 16'h0004);
        tick();
        idle(3);

        for (int i = 1; i <= 3; i++) begin
            set1(1, OP_ADD, 2'd0, 16'(i), 16'd0);
            tick();
        end
        idle(3);

        // flush kills the op accepted the cycle before
        set0(1, OP_ADD, 2'd1, 16'h0100, 16'h0001);
        tick();
        set0(1, OP_ADD, 2'd0, 16'h0200, 16'h0002);
        set1(1, OP_ADD, 2'd0, 16'h0300, 16'h0003);
        flush0 = 1'b1;
        tick();
        idle(4);

        // async reset with issue and response stages both occupied
        set0(1, OP_ADD, 2'd0, 16'h0011, 16'h0022);
        tick();
        set0(0, 5'd0, 2'd0, 16'd0, 16'd0);
        set1(1, 5'd7, 2'd3, 16'h0033, 16'h0044);
        tick();
        set1(0, 5'd0, 2'd0, 16'd0, 16'd0);
        chk("busy_before_rst", busy, 1'b1);
        #2 rst_n = 1'b0;
        q.delete();
        m_iss_vld = 0;
        pref = 0;
        #1;
        chk("async_rst_resp0", resp0_valid, 1'b0);
        chk("async_rst_resp1", resp1_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) begin
            set0(1, 5'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
            set1(1, 5'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        idle(3);

        repeat (400) begin
            set0($urandom_range(0, 2) != 0, ($urandom_range(0, 1) == 1) ? OP_ADD : 5'($urandom),
                 2'($urandom), 16'($urandom), 16'($urandom));
            set1($urandom_range(0, 2) != 0, ($urandom_range(0, 1) == 1) ? OP_ADD : 5'($urandom),
                 2'($urandom), 16'($urandom), 16'($urandom));
            flush0 = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle(4);
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU (ALU core plus ALU control decoder) between two requesters.
  - Requester 0: pipeline execute stage.
  - Requester 1: secondary engine, e.g. address generator or debug unit.
- Accepts at most one operation per cycle, arbitrates round-robin, and registers the op into an issue stage that drives the ALU.
- Captures the ALU result and returns it to the owning requester with a fixed 2-cycle latency.
- Supports a flush from requester 0 that kills its in-flight operations.

Parameters:
- DATA_W, 16, operand/result width.
- OP_W, 5, ALU opcode width.
- FUNCT_W, 2, ALU function-field width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has an op.
- req0_op  input  OP_W  opcode for requester 0.
- req0_funct  input  FUNCT_W  function field for requester 0.
- req0_a  input  DATA_W  operand A for requester 0.
- req0_b  input  DATA_W  operand B for requester 0.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req1_valid, req1_op, req1_funct, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- flush0  input  1  kill requester-0 in-flight ops.
- alu_op  output  OP_W  to ALU control.
- alu_funct  output  FUNCT_W  to ALU control.
- alu_a  output  DATA_W  to ALU.
- alu_b  output  DATA_W  to ALU.
- alu_result  input  DATA_W  combinational ALU result for the current issue regs.
- resp0_valid  output  1  result for requester 0, one-cycle pulse.
- resp1_valid  output  1  result for requester 1, one-cycle pulse.
- resp_data  output  DATA_W  result data, qualifies either resp valid.
- busy  output  1  issue or response stage occupied.

Behaviour:
- Reset (rst_n low, async): all of the following cleared to 0:
  - outputs: req*_ready, resp*_valid, resp_data, alu_op, alu_funct, alu_a, alu_b, busy;
  - issue valid and issue owner;
  - RR pointer (0 = requester 0 preferred next).
- Reset mid-operation discards all in-flight ops; no response is produced for them.
- Readiness:
  - req*_ready is combinational, from the valids, the RR pointer and flush0.
  - Exactly one requester is granted when any is valid.
  - A grant implies ready high in the same cycle; the transfer occurs at the clock edge.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the pointer's preferred requester is granted.
  - Pointer update on each grant: pointer <= other requester.
  - No grant: pointer holds.
- Pipeline:
  - Stage 1 (issue): at the accept edge N, latch op, funct, a, b, owner and issue_valid. alu_* outputs come directly from the issue regs.
  - No accept: issue_valid is cleared, and alu_* hold their last values (no toggling requirement).
  - Stage 2 (response): at edge N+1, if issue_valid, resp_data <= alu_result and resp<owner>_valid <= 1.
  - Response is visible in cycle N+2 (latency 2 edges after accept).
  - resp*_valid is a single-cycle pulse. There is no response backpressure; requesters must consume it.
- Throughput: one accept per cycle, fully pipelined, no bubbles.
- Opcode handling: transparent. HALT (00000) and unrecognised opcodes are forwarded and return whatever alu_result gives.
- flush0:
  - req0_ready is forced low while flush0 is high; requester 1 may still be granted in that cycle.
  - An issue stage holding owner 0 has issue_valid cleared at the next edge, so no resp0 results.
  - A resp0_valid scheduled for the next cycle is suppressed; a resp0_valid already visible in the flush cycle stays.
  - Requester-1 ops are never affected.
- Pointer when flush0 blocks requester 0: requester 1 is granted as the sole requester and the pointer is updated normally.
- busy = issue_valid OR resp0_valid OR resp1_valid.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRI_EN.
- Defined: requester 0 always wins when both are valid and the RR pointer is not implemented. Requester 1 is granted only when req0_valid is low or flush0 is high.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Single op, req0 only:
  - Stimulus: op=11011, funct=00, a=0x0003, b=0x0004, with the ALU model adding.
  - Required: req0_ready=1 at cycle 0; alu_a=3 and alu_b=4 at cycle 1; resp0_valid=1 and resp_data=0x0007 at cycle 2; resp1_valid=0.
- Contention: both requesters valid for 4 consecutive cycles, pointer at reset.
  - Round-robin build: grants 0,1,0,1, with responses in the same order 2 cycles later.
  - ALU_ARB_FIXED_PRI_EN build: grants 0,0,0,0 and req1_ready never asserts.
- Back-to-back req1:
  - Stimulus: 3 ops on requester 1 with a=1,2,3 and b=0, op ADD.
  - Required: resp1_valid high for 3 consecutive cycles with resp_data 1,2,3; busy low one cycle after the last response.
- Flush:
  - Stimulus: req0 accepted at cycle 0, then flush0=1 at cycle 1 while req1_valid=1.
  - Required: resp0_valid never asserts for the killed op; req1 is granted at cycle 1 and its resp1_valid appears at cycle 3.
- Async reset:
  - Stimulus: rst_n pulled low mid-cycle with issue and response stages full.
  - Required: resp*_valid and busy drop immediately (same cycle, no clock edge). After release, the first grant goes to requester 0 when both are valid.
